// File: rtl/ctrl_exposure_time.sv
// Exposure-time register (ms, 5-bit): steps +/-1 per cycle while a request is held, clamped to [EXP_MIN, EXP_MAX].
// Latency: one cycle, request sampled at edge k shows on EX_time after edge k; all outputs registered.
// Backpressure: none. Requests are accepted every cycle; simultaneous requests cancel and steps saturate at the bounds.
module ctrl_exposure_time #(
    parameter int unsigned EXP_MIN   = 2,
    parameter int unsigned EXP_MAX   = 30,
    parameter int unsigned EXP_RESET = 2
) (
    input  logic       Clk,
    input  logic       Reset_n,
    input  logic       Exp_increase,
    input  logic       Exp_decrease,
    output logic [4:0] EX_time,
    output logic       EX_at_max,
    output logic       EX_at_min
);

    if (!((EXP_MIN <= EXP_RESET) && (EXP_RESET <= EXP_MAX) && (EXP_MAX <= 31))) begin : g_bad_params
        $error("ctrl_exposure_time: need EXP_MIN <= EXP_RESET <= EXP_MAX <= 31");
    end

    localparam logic [4:0] MIN_VAL    = 5'(EXP_MIN);
    localparam logic [4:0] MAX_VAL    = 5'(EXP_MAX);
    localparam logic [4:0] RST_VAL    = 5'(EXP_RESET);
    localparam logic       RST_AT_MIN = (EXP_RESET == EXP_MIN);
    localparam logic       RST_AT_MAX = (EXP_RESET == EXP_MAX);

    logic [4:0] ex_time_nxt;

    always_comb begin
        ex_time_nxt = EX_time;
        // Out-of-range values snap back to the nearest bound, ignoring requests.
        if (EX_time < MIN_VAL) begin
            ex_time_nxt = MIN_VAL;
        end else if (EX_time > MAX_VAL) begin
            ex_time_nxt = MAX_VAL;
        end else begin
            unique case ({Exp_increase, Exp_decrease})
                2'b10: if (EX_time < MAX_VAL) ex_time_nxt = EX_time + 5'd1;
                2'b01: if (EX_time > MIN_VAL) ex_time_nxt = EX_time - 5'd1;
                default: ex_time_nxt = EX_time;
            endcase
        end
    end

    // Flags come from the next-state value so they never lag EX_time.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            EX_time   <= RST_VAL;
            EX_at_min <= RST_AT_MIN;
            EX_at_max <= RST_AT_MAX;
        end else begin
            EX_time   <= ex_time_nxt;
            EX_at_min <= (ex_time_nxt == MIN_VAL);
            EX_at_max <= (ex_time_nxt == MAX_VAL);
        end
    end

endmodule

// File: tb/tb_ctrl_exposure_time.sv
// Directed bench for ctrl_exposure_time with default parameters (range 2..30, reset 2).
module tb_ctrl_exposure_time;

    logic       Clk = 1'b0;
    logic       Reset_n = 1'b0;
    logic       Exp_increase = 1'b0;
    logic       Exp_decrease = 1'b0;
    logic [4:0] EX_time;
    logic       EX_at_max;
    logic       EX_at_min;

    int checks = 0;
    int errors = 0;
    int exp_v;

    ctrl_exposure_time dut (
        .Clk          (Clk),
        .Reset_n      (Reset_n),
        .Exp_increase (Exp_increase),
        .Exp_decrease (Exp_decrease),
        .EX_time      (EX_time),
        .EX_at_max    (EX_at_max),
        .EX_at_min    (EX_at_min)
    );

    initial forever #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic check_state(input string tag, input int t, input logic mn, input logic mx);
        check({tag, ".time"}, 32'(EX_time), 32'(t));
        check({tag, ".at_min"}, 32'(EX_at_min), 32'(mn));
        check({tag, ".at_max"}, 32'(EX_at_max), 32'(mx));
    endtask

    // One-cycle request, then an idle cycle; checks the value after the pulse and after the idle.
    task automatic pulse(input logic inc, input logic dec, input int expv, input string tag);
        Exp_increase = inc;
        Exp_decrease = dec;
        @(negedge Clk);
        Exp_increase = 1'b0;
        Exp_decrease = 1'b0;
        check({tag, ".step"}, 32'(EX_time), 32'(expv));
        @(negedge Clk);
        check({tag, ".idle"}, 32'(EX_time), 32'(expv));
    endtask

    initial begin
        // Reset held low while inputs toggle across clock edges.
        for (int i = 0; i < 4; i++) begin
            @(negedge Clk);
            Exp_increase = i[0];
            Exp_decrease = i[1];
            check("reset_hold", 32'(EX_time), 32'd2);
        end
        @(negedge Clk);
        check_state("reset", 2, 1'b1, 1'b0);

        Exp_increase = 1'b0;
        Exp_decrease = 1'b0;
        Reset_n = 1'b1;
        @(negedge Clk);
        @(negedge Clk);
        check_state("release_idle", 2, 1'b1, 1'b0);

        pulse(1'b1, 1'b0, 3, "inc1");
        pulse(1'b1, 1'b0, 4, "inc2");
        pulse(1'b1, 1'b0, 5, "inc3");
        pulse(1'b1, 1'b0, 6, "inc4");
        pulse(1'b0, 1'b1, 5, "dec1");
        pulse(1'b0, 1'b1, 4, "dec2");
        pulse(1'b0, 1'b1, 3, "dec3");
        pulse(1'b0, 1'b1, 2, "dec4");
        check_state("at_floor", 2, 1'b1, 1'b0);

        // Upper saturation: hold increase for 40 edges from 2.
        Exp_increase = 1'b1;
        for (int i = 1; i <= 40; i++) begin
            @(negedge Clk);
            exp_v = (2 + i > 30) ? 30 : 2 + i;
            check("sat_up.time", 32'(EX_time), 32'(exp_v));
            check("sat_up.at_max", 32'(EX_at_max), 32'(exp_v == 30));
        end
        Exp_increase = 1'b0;
        check_state("top", 30, 1'b0, 1'b1);

        // Lower saturation: hold decrease for 40 edges from 30.
        Exp_decrease = 1'b1;
        for (int i = 1; i <= 40; i++) begin
            @(negedge Clk);
            exp_v = (30 - i < 2) ? 2 : 30 - i;
            check("sat_dn.time", 32'(EX_time), 32'(exp_v));
            check("sat_dn.at_min", 32'(EX_at_min), 32'(exp_v == 2));
        end
        Exp_decrease = 1'b0;
        check_state("bottom", 2, 1'b1, 1'b0);

        // Climb to 10, then both requests together must hold.
        Exp_increase = 1'b1;
        repeat (8) @(negedge Clk);
        Exp_increase = 1'b0;
        check("to_10", 32'(EX_time), 32'd10);
        Exp_increase = 1'b1;
        Exp_decrease = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge Clk);
            check("both_held", 32'(EX_time), 32'd10);
        end
        Exp_increase = 1'b0;
        Exp_decrease = 1'b0;

        // Climb to 17, then assert reset between edges.
        Exp_increase = 1'b1;
        repeat (7) @(negedge Clk);
        Exp_increase = 1'b0;
        check_state("at_17", 17, 1'b0, 1'b0);
        @(posedge Clk);
        #3;
        Reset_n = 1'b0;
        #1;
        check_state("async_reset", 2, 1'b1, 1'b0);
        @(negedge Clk);
        check("reset_still", 32'(EX_time), 32'd2);

        // First edge after release may already step.
        Exp_increase = 1'b1;
        Reset_n = 1'b1;
        @(negedge Clk);
        Exp_increase = 1'b0;
        check_state("first_edge_step", 3, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
